trap_ctrl: RTL and testbench
============================

# trap_ctrl

Machine-mode trap initiator for the RV32I pipeline. It collects synchronous exceptions from the execute stage and level-sensitive interrupt requests, and arbitrates them against mstatus.MIE and mie. It then drives the trap pulse and the mcause/mepc/mtval/mip/mstatus values that the execute stage and CSR file consume, and afterwards issues a PC redirect to the handler. It also computes the mstatus update for mret.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, value of redirect_pc out of reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- ex_valid  in  1  EX holds a real instruction (not a bubble).
- ex_pc  in  32  PC of the EX instruction.
- exc_req  in  1  synchronous exception raised by the EX instruction.
- exc_code  in  4  exception cause code (0..11).
- exc_tval  in  32  faulting address or instruction bits.
- mret  in  1  EX instruction is mret.
- irq_ext  in  1  external interrupt level.
- irq_sw  in  1  software interrupt level.
- mstatus  in  32  current mstatus from the CSR file.
- mie  in  32  current mie from the CSR file.
- mtvec  in  32  trap vector. Bits [1:0]: 00 = direct, 01 = vectored.
- mepc_cur  in  32  current mepc, used as the mret target.
- tmr_wr  in  1  timer register write strobe.
- tmr_sel  in  2  0 = mtime lo, 1 = mtime hi, 2 = mtimecmp lo, 3 = mtimecmp hi.
- tmr_wdata  in  32  timer write data.
- tmr_rdata  out  32  timer read data selected by tmr_sel (combinational).
- trap  out  1  one-cycle trap pulse to EX and the CSR file.
- mcause  out  32  cause. Bit 31 = interrupt.
- mepc  out  32  PC to save.
- mtval  out  32  trap value.
- mip  out  32  pending bits: MEIP bit 11, MTIP bit 7, MSIP bit 3.
- mstatus_nxt  out  32  mstatus write value, valid when trap or mret.
- stall  out  1  freeze IF/ID while the controller is not IDLE.
- redirect  out  1  one-cycle PC redirect strobe.
- redirect_pc  out  32  new fetch PC.

## Operation
FSM states: IDLE, TRAP, REDIR.

- **IDLE**
  - Evaluate a take condition each cycle, and only when ex_valid = 1 and trap = 0.
  - Priority: exc_req first, then MEI, then MSI, then MTI.
  - An interrupt is eligible only when mstatus[3] (MIE) = 1 and its mie bit and mip bit are both 1.
  - When taken: register mcause, mepc = ex_pc, and mtval, then go to TRAP.
    - Exception: mcause = {28'b0, exc_code}, mtval = exc_tval.
    - Interrupt: mcause = {1'b1, 27'b0, code}, with code = 11, 3 or 7; mtval = 0.
- **TRAP**
  - trap = 1 and stall = 1.
  - mstatus_nxt = mstatus with MPIE(7) = MIE(3), MIE = 0, MPP(12:11) = 2'b11.
  - Always go to REDIR.
- **REDIR**
  - redirect = 1 and stall = 1.
  - redirect_pc = {mtvec[31:2], 2'b00}.
  - If mtvec[1:0] = 01 and mcause[31] = 1, add 4*mcause[3:0] to that base.
  - Always go to IDLE.
- **mret in IDLE, with no take condition**
  - Same cycle, combinationally: mstatus_nxt = MIE = MPIE, MPIE = 1, MPP = 00; redirect = 1; redirect_pc = mepc_cur.
  - The FSM stays in IDLE.
- **mret together with an interrupt take**: the interrupt wins. The mret is flushed and the saved mepc is the mret's PC.
- **exc_req together with mret** on the same instruction: the exception wins.
- **mip**: registered every cycle from irq_ext, irq_sw and MTIP. All other bits are 0.
- **Arithmetic**: all address arithmetic is modulo 2^32 with no overflow detection.

## Timing
- Detection to trap: 1 cycle. trap to redirect: 1 cycle. Each detected event costs 3 cycles of stall, counting from the detection cycle.
- mcause, mepc and mtval hold their values from TRAP until the next take.
- Interrupts arriving during TRAP or REDIR stay pending in mip and are evaluated again in IDLE.
- Reset values:
  - FSM = IDLE.
  - trap = 0, stall = 0, redirect = 0.
  - mcause = 0, mepc = 0, mtval = 0, mip = 0.
  - redirect_pc = RESET_PC.
  - mtime = 0, mtimecmp = all ones.
- Reset asserted mid-trap: outputs go to their reset values asynchronously, and no redirect is issued.

## Configuration
- TRAP_CTRL_TIMER_EN defined:
  - 64-bit mtime increments every clock and wraps from all ones to 0.
  - MTIP = (mtime >= mtimecmp), unsigned.
  - tmr_wr writes the selected 32-bit half. A write to mtime takes precedence over that cycle's increment.
- Not defined:
  - No timer registers exist, and MTIP = 0.
  - tmr_rdata = 0 and tmr_wr is ignored.

## Structure
- Shared package `trap_pkg` holds:
  - the state enum (IDLE/TRAP/REDIR);
  - cause codes: IRQ_MEI = 11, IRQ_MSI = 3, IRQ_MTI = 7, EXC_ILLEGAL = 2, EXC_ECALL_M = 11;
  - mstatus bit indices: MIE = 3, MPIE = 7, MPP = 12:11.
- One sub-module, `mtimer`: the mtime/mtimecmp registers, compare logic and read mux. It is instantiated only under TRAP_CTRL_TIMER_EN.

## Test plan
- **Illegal instruction**: exc_req = 1, exc_code = 2, ex_pc = 0x100, exc_tval = 0xDEADBEEF, mtvec = 0x200 → next cycle trap = 1, mcause = 2, mepc = 0x100, mtval = 0xDEADBEEF; following cycle redirect = 1, redirect_pc = 0x200.
- **Vectored external interrupt**: mstatus = 0x8, mie[11] = 1, irq_ext = 1, mtvec = 0x401, ex_pc = 0x80 → mcause = 0x8000000B, mepc = 0x80, redirect_pc = 0x42C, mstatus_nxt = 0x1880.
- **Masked interrupt**: irq_sw = 1 with MIE = 0 → mip[3] = 1, trap stays 0 for 20 cycles. Set MIE = 1 → trap within 2 cycles, mcause = 0x80000003.
- **Simultaneous events**: exc_req (code 11) with irq_ext enabled in the same cycle → mcause = 11. After the redirect and the handler's mret, the interrupt is taken with mcause = 0x8000000B.
- **mret**: mstatus = 0x80, mepc_cur = 0x104 → same cycle redirect = 1, redirect_pc = 0x104, mstatus_nxt = 0x88, no trap.
- **Timer (TRAP_CTRL_TIMER_EN)**: write mtimecmp = 10 → mip[7] rises when mtime reaches 10. Trap taken with mcause = 0x80000007. Write mtime hi = 0xFFFFFFFF, lo = 0xFFFFFFFE → mtime wraps to 0 two cycles later.

Source files
------------

// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared state type, cause codes and mstatus helpers for trap_ctrl
package trap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAP  = 2'd1,
        REDIR = 2'd2
    } state_t;

    localparam logic [3:0] IRQ_MEI     = 4'd11;
    localparam logic [3:0] IRQ_MSI     = 4'd3;
    localparam logic [3:0] IRQ_MTI     = 4'd7;
    localparam logic [3:0] EXC_ILLEGAL = 4'd2;
    localparam logic [3:0] EXC_ECALL_M = 4'd11;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam int MIP_MEIP = 11;
    localparam int MIP_MTIP = 7;
    localparam int MIP_MSIP = 3;

    // Entering a trap: stash MIE in MPIE, mask interrupts, record M-mode as previous privilege
    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] m);
        logic [31:0] r;
        r = m;
        r[MSTATUS_MPIE] = m[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    // Returning with mret: restore MIE from MPIE, set MPIE, drop MPP to U
    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] m);
        logic [31:0] r;
        r = m;
        r[MSTATUS_MIE]  = m[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
        return r;
    endfunction

endpackage

// File: rtl/trap_ctrl_mtimer.sv
// rtl/trap_ctrl_mtimer.sv - 64-bit mtime/mtimecmp pair with compare and read mux
module mtimer (
    input  logic        clk,
    input  logic        rst,
    input  logic        tmr_wr,
    input  logic [1:0]  tmr_sel,
    input  logic [31:0] tmr_wdata,
    output logic [31:0] tmr_rdata,
    output logic        mtip
);

    logic [63:0] mtime;
    logic [63:0] mtimecmp;

    // Free-running mtime; a software write to either half replaces that cycle's increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime    <= 64'd0;
            mtimecmp <= '1;
        end else begin
            if (tmr_wr && tmr_sel == 2'd0) begin
                mtime <= {mtime[63:32], tmr_wdata};
            end else if (tmr_wr && tmr_sel == 2'd1) begin
                mtime <= {tmr_wdata, mtime[31:0]};
            end else begin
                mtime <= mtime + 64'd1;
            end
            if (tmr_wr && tmr_sel == 2'd2) begin
                mtimecmp <= {mtimecmp[63:32], tmr_wdata};
            end else if (tmr_wr && tmr_sel == 2'd3) begin
                mtimecmp <= {tmr_wdata, mtimecmp[31:0]};
            end
        end
    end

    // Read mux over the four 32-bit halves
    always_comb begin
        tmr_rdata = 32'd0;
        case (tmr_sel)
            2'd0:    tmr_rdata = mtime[31:0];
            2'd1:    tmr_rdata = mtime[63:32];
            2'd2:    tmr_rdata = mtimecmp[31:0];
            default: tmr_rdata = mtimecmp[63:32];
        endcase
    end

    assign mtip = (mtime >= mtimecmp);

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap initiator; optional timer under TRAP_CTRL_TIMER_EN
module trap_ctrl
    import trap_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        exc_req,
    input  logic [3:0]  exc_code,
    input  logic [31:0] exc_tval,
    input  logic        mret,
    input  logic        irq_ext,
    input  logic        irq_sw,
    input  logic [31:0] mstatus,
    input  logic [31:0] mie,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc_cur,
    input  logic        tmr_wr,
    input  logic [1:0]  tmr_sel,
    input  logic [31:0] tmr_wdata,
    output logic [31:0] tmr_rdata,
    output logic        trap,
    output logic [31:0] mcause,
    output logic [31:0] mepc,
    output logic [31:0] mtval,
    output logic [31:0] mip,
    output logic [31:0] mstatus_nxt,
    output logic        stall,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    state_t      state;
    logic        mtip;
    logic        trap_q;
    logic        redir_q;
    logic [31:0] redirect_pc_q;
    logic        irq_en;
    logic        take_mei;
    logic        take_msi;
    logic        take_mti;
    logic        take;
    logic        mret_fire;
    logic [3:0]  irq_code;
    logic [31:0] vec_off;
    logic [31:0] vec_pc;
    logic        unused_mie;

`ifdef TRAP_CTRL_TIMER_EN
    mtimer u_mtimer (
        .clk       (clk),
        .rst       (rst),
        .tmr_wr    (tmr_wr),
        .tmr_sel   (tmr_sel),
        .tmr_wdata (tmr_wdata),
        .tmr_rdata (tmr_rdata),
        .mtip      (mtip)
    );
`else
    logic unused_tmr;
    assign mtip       = 1'b0;
    assign tmr_rdata  = 32'd0;
    assign unused_tmr = ^{tmr_wr, tmr_sel, tmr_wdata};
`endif

    assign unused_mie = ^{mie[31:12], mie[10:8], mie[6:4], mie[2:0]};

    // Interrupts are eligible only from the registered pending bits, gated by MIE and mie
    assign irq_en   = mstatus[MSTATUS_MIE];
    assign take_mei = irq_en & mie[MIP_MEIP] & mip[MIP_MEIP];
    assign take_msi = irq_en & mie[MIP_MSIP] & mip[MIP_MSIP];
    assign take_mti = irq_en & mie[MIP_MTIP] & mip[MIP_MTIP];

    assign take      = (state == IDLE) & ex_valid & ~trap_q
                     & (exc_req | take_mei | take_msi | take_mti);
    // A trap on the same instruction flushes the mret
    assign mret_fire = (state == IDLE) & ex_valid & mret & ~take;

    // Interrupt cause code in priority order MEI, MSI, MTI
    always_comb begin
        irq_code = IRQ_MTI;
        if (take_mei) begin
            irq_code = IRQ_MEI;
        end else if (take_msi) begin
            irq_code = IRQ_MSI;
        end
    end

    // Handler address: direct base, plus 4*cause for vectored interrupts
    assign vec_off = (mtvec[1:0] == 2'b01 && mcause[31]) ? {26'd0, mcause[3:0], 2'b00} : 32'd0;
    assign vec_pc  = {mtvec[31:2], 2'b00} + vec_off;

    // Pending bits sampled every cycle so late arrivals are re-evaluated back in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mip <= 32'd0;
        end else begin
            mip <= '0;
            mip[MIP_MEIP] <= irq_ext;
            mip[MIP_MTIP] <= mtip;
            mip[MIP_MSIP] <= irq_sw;
        end
    end

    // Trap sequencer: IDLE detects, TRAP pulses trap, REDIR pulses the handler redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            trap_q        <= 1'b0;
            redir_q       <= 1'b0;
            stall         <= 1'b0;
            mcause        <= 32'd0;
            mepc          <= 32'd0;
            mtval         <= 32'd0;
            redirect_pc_q <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        state  <= TRAP;
                        trap_q <= 1'b1;
                        stall  <= 1'b1;
                        mepc   <= ex_pc;
                        if (exc_req) begin
                            mcause <= {28'd0, exc_code};
                            mtval  <= exc_tval;
                        end else begin
                            mcause <= {1'b1, 27'd0, irq_code};
                            mtval  <= 32'd0;
                        end
                    end
                end
                TRAP: begin
                    state         <= REDIR;
                    trap_q        <= 1'b0;
                    redir_q       <= 1'b1;
                    redirect_pc_q <= vec_pc;
                end
                REDIR: begin
                    state   <= IDLE;
                    redir_q <= 1'b0;
                    stall   <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    trap_q  <= 1'b0;
                    redir_q <= 1'b0;
                    stall   <= 1'b0;
                end
            endcase
        end
    end

    // mstatus write value for the trap pulse or an accepted mret
    always_comb begin
        mstatus_nxt = mstatus;
        if (trap_q) begin
            mstatus_nxt = mstatus_on_trap(mstatus);
        end else if (mret_fire) begin
            mstatus_nxt = mstatus_on_mret(mstatus);
        end
    end

    assign trap        = trap_q;
    assign redirect    = redir_q | mret_fire;
    assign redirect_pc = mret_fire ? mepc_cur : redirect_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - self-checking bench for trap_ctrl
module tb_trap_ctrl;
    import trap_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk, rst, ex_valid, exc_req, mret, irq_ext, irq_sw, tmr_wr;
    logic [31:0] ex_pc, exc_tval, mstatus, mie, mtvec, mepc_cur, tmr_wdata, tmr_rdata;
    logic [3:0]  exc_code;
    logic [1:0]  tmr_sel;
    logic        trap, stall, redirect;
    logic [31:0] mcause, mepc, mtval, mip, mstatus_nxt, redirect_pc;

    int checks = 0;
    int errors = 0;

    trap_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc), .exc_req(exc_req),
        .exc_code(exc_code), .exc_tval(exc_tval), .mret(mret), .irq_ext(irq_ext),
        .irq_sw(irq_sw), .mstatus(mstatus), .mie(mie), .mtvec(mtvec), .mepc_cur(mepc_cur),
        .tmr_wr(tmr_wr), .tmr_sel(tmr_sel), .tmr_wdata(tmr_wdata), .tmr_rdata(tmr_rdata),
        .trap(trap), .mcause(mcause), .mepc(mepc), .mtval(mtval), .mip(mip),
        .mstatus_nxt(mstatus_nxt), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ex_valid = 0; ex_pc = 0; exc_req = 0; exc_code = 0; exc_tval = 0; mret = 0;
        irq_ext = 0; irq_sw = 0; mstatus = 0; mie = 0; mtvec = 0; mepc_cur = 0;
        tmr_wr = 0; tmr_sel = 0; tmr_wdata = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        cyc();
        rst = 0;
        cyc();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        cyc();
        cyc();
        checks++; if ({trap, stall, redirect} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b exp 000", {trap, stall, redirect}); end
        checks++; if (mcause !== 32'd0) begin errors++; $display("FAIL reset_mcause got %h exp 0", mcause); end
        checks++; if (mepc !== 32'd0) begin errors++; $display("FAIL reset_mepc got %h exp 0", mepc); end
        checks++; if (mtval !== 32'd0) begin errors++; $display("FAIL reset_mtval got %h exp 0", mtval); end
        checks++; if (mip !== 32'd0) begin errors++; $display("FAIL reset_mip got %h exp 0", mip); end
        checks++; if (redirect_pc !== RST_PC) begin errors++; $display("FAIL reset_redirect_pc got %h exp %h", redirect_pc, RST_PC); end
        rst = 0;
        cyc();
    endtask

    task automatic test_illegal();
        do_reset();
        mtvec = 32'h200; ex_pc = 32'h100; exc_req = 1; exc_code = EXC_ILLEGAL;
        exc_tval = 32'hDEADBEEF; ex_valid = 1;
        cyc();
        ex_valid = 0; exc_req = 0;
        checks++; if ({trap, stall, redirect} !== 3'b110) begin errors++; $display("FAIL ill_trap got %b exp 110", {trap, stall, redirect}); end
        checks++; if (mcause !== 32'd2) begin errors++; $display("FAIL ill_mcause got %h exp 2", mcause); end
        checks++; if (mepc !== 32'h100) begin errors++; $display("FAIL ill_mepc got %h exp 100", mepc); end
        checks++; if (mtval !== 32'hDEADBEEF) begin errors++; $display("FAIL ill_mtval got %h exp deadbeef", mtval); end
        checks++; if (mstatus_nxt !== 32'h1800) begin errors++; $display("FAIL ill_mstatus_nxt got %h exp 1800", mstatus_nxt); end
        cyc();
        checks++; if ({trap, stall, redirect} !== 3'b011) begin errors++; $display("FAIL ill_redir got %b exp 011", {trap, stall, redirect}); end
        checks++; if (redirect_pc !== 32'h200) begin errors++; $display("FAIL ill_redirect_pc got %h exp 200", redirect_pc); end
        cyc();
        checks++; if ({trap, stall, redirect} !== 3'b000) begin errors++; $display("FAIL ill_idle got %b exp 000", {trap, stall, redirect}); end
    endtask

    task automatic test_vectored();
        do_reset();
        mstatus = 32'h8; mie = 32'h800; irq_ext = 1; mtvec = 32'h401; ex_pc = 32'h80;
        cyc();
        checks++; if (mip !== 32'h800) begin errors++; $display("FAIL vec_mip got %h exp 800", mip); end
        ex_valid = 1;
        cyc();
        ex_valid = 0; irq_ext = 0;
        checks++; if (trap !== 1'b1) begin errors++; $display("FAIL vec_trap got %b exp 1", trap); end
        checks++; if (mcause !== 32'h8000000B) begin errors++; $display("FAIL vec_mcause got %h exp 8000000b", mcause); end
        checks++; if (mepc !== 32'h80) begin errors++; $display("FAIL vec_mepc got %h exp 80", mepc); end
        checks++; if (mtval !== 32'h0) begin errors++; $display("FAIL vec_mtval got %h exp 0", mtval); end
        checks++; if (mstatus_nxt !== 32'h1880) begin errors++; $display("FAIL vec_mstatus_nxt got %h exp 1880", mstatus_nxt); end
        cyc();
        checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h42C) begin errors++; $display("FAIL vec_redirect got %b/%h exp 1/42c", redirect, redirect_pc); end
        cyc();
    endtask

    task automatic test_masked();
        bit seen;
        do_reset();
        irq_sw = 1; mie = 32'h8; mstatus = 32'h0; ex_valid = 1; ex_pc = 32'h300; mtvec = 32'h200;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (trap) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL masked_no_trap got %b exp 0", seen); end
        checks++; if (mip !== 32'h8) begin errors++; $display("FAIL masked_mip got %h exp 8", mip); end
        mstatus = 32'h8;
        for (int i = 0; i < 2; i++) begin
            cyc();
            if (trap) begin
                seen = 1;
                break;
            end
        end
        ex_valid = 0; irq_sw = 0;
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL masked_trap_timeout got %b exp 1", seen); end
        checks++; if (mcause !== 32'h80000003) begin errors++; $display("FAIL masked_mcause got %h exp 80000003", mcause); end
        cyc();
        cyc();
    endtask

    task automatic test_simultaneous();
        do_reset();
        mstatus = 32'h8; mie = 32'h800; irq_ext = 1; mtvec = 32'h200;
        cyc();
        exc_req = 1; exc_code = EXC_ECALL_M; exc_tval = 32'h0; ex_pc = 32'h500; ex_valid = 1;
        cyc();
        ex_valid = 0; exc_req = 0;
        checks++; if (trap !== 1'b1 || mcause !== 32'd11) begin errors++; $display("FAIL sim_exc got %b/%h exp 1/b", trap, mcause); end
        cyc();
        checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h200) begin errors++; $display("FAIL sim_redirect got %b/%h exp 1/200", redirect, redirect_pc); end
        cyc();
        mstatus = 32'h80; mepc_cur = 32'h504; mret = 1; ex_valid = 1; ex_pc = 32'h20C;
        #1;
        checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h504 || mstatus_nxt !== 32'h88) begin errors++; $display("FAIL sim_mret got %b/%h/%h exp 1/504/88", redirect, redirect_pc, mstatus_nxt); end
        cyc();
        mret = 0; mstatus = 32'h88; ex_pc = 32'h504;
        cyc();
        ex_valid = 0; irq_ext = 0;
        checks++; if (trap !== 1'b1 || mcause !== 32'h8000000B || mepc !== 32'h504) begin errors++; $display("FAIL sim_irq got %b/%h/%h exp 1/8000000b/504", trap, mcause, mepc); end
        cyc();
        cyc();
    endtask

    task automatic test_mret();
        do_reset();
        mstatus = 32'h80; mepc_cur = 32'h104; mret = 1; ex_valid = 1;
        #1;
        checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h104) begin errors++; $display("FAIL mret_redirect got %b/%h exp 1/104", redirect, redirect_pc); end
        checks++; if (mstatus_nxt !== 32'h88) begin errors++; $display("FAIL mret_mstatus_nxt got %h exp 88", mstatus_nxt); end
        cyc();
        mret = 0; ex_valid = 0;
        #1;
        checks++; if ({trap, stall, redirect} !== 3'b000) begin errors++; $display("FAIL mret_after got %b exp 000", {trap, stall, redirect}); end
        // mret racing an interrupt: interrupt wins, mret flushed, its PC saved
        mstatus = 32'h88; mie = 32'h800; irq_ext = 1;
        cyc();
        mret = 1; ex_valid = 1; ex_pc = 32'h600;
        #1;
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL mret_flushed got %b exp 0", redirect); end
        cyc();
        mret = 0; ex_valid = 0; irq_ext = 0;
        checks++; if (trap !== 1'b1 || mepc !== 32'h600 || mcause !== 32'h8000000B) begin errors++; $display("FAIL mret_irq_wins got %b/%h/%h exp 1/600/8000000b", trap, mepc, mcause); end
        cyc();
        cyc();
    endtask

    task automatic test_reset_mid_trap();
        do_reset();
        mtvec = 32'h300; ex_pc = 32'h40; exc_req = 1; exc_code = 4'd5; ex_valid = 1;
        cyc();
        ex_valid = 0; exc_req = 0;
        #2;
        rst = 1;
        #1;
        checks++; if ({trap, stall, redirect} !== 3'b000 || mcause !== 32'd0 || redirect_pc !== RST_PC) begin errors++; $display("FAIL midrst_async got %b/%h/%h exp 000/0/%h", {trap, stall, redirect}, mcause, redirect_pc, RST_PC); end
        cyc();
        rst = 0;
        cyc();
        checks++; if (redirect !== 1'b0 || redirect_pc !== RST_PC) begin errors++; $display("FAIL midrst_no_redirect got %b/%h exp 0/%h", redirect, redirect_pc, RST_PC); end
    endtask

    task automatic test_random();
        logic [31:0] e_cause, e_tval, e_vec, e_mip, st;
        bit take, is_int;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            ex_valid = 0;
            irq_ext  = 1'($urandom);
            irq_sw   = 1'($urandom);
            mie      = $urandom;
            mstatus  = $urandom;
            mtvec    = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
            ex_pc    = $urandom;
            exc_req  = ($urandom_range(0, 3) == 0);
            exc_code = 4'($urandom_range(0, 11));
            exc_tval = $urandom;
            mret     = 1'($urandom);
            mepc_cur = $urandom;
            cyc();
            e_mip = (irq_ext ? 32'h800 : 32'h0) + (irq_sw ? 32'h8 : 32'h0);
            checks++; if (mip !== e_mip) begin errors++; $display("FAIL rnd_mip[%0d] got %h exp %h", n, mip, e_mip); end
            // reference: exception first, then MEI, MSI (MTI never pending here)
            take = 1; is_int = 0; e_tval = 0; e_cause = 0;
            if (exc_req) begin
                e_cause = {28'd0, exc_code}; e_tval = exc_tval;
            end else if (mstatus[3] && mie[11] && irq_ext) begin
                e_cause = 32'h8000000B; is_int = 1;
            end else if (mstatus[3] && mie[3] && irq_sw) begin
                e_cause = 32'h80000003; is_int = 1;
            end else begin
                take = 0;
            end
            e_vec = (mtvec & 32'hFFFF_FFFC) + ((is_int && mtvec[1:0] == 2'b01) ? 4 * e_cause[3:0] : 0);
            ex_valid = 1;
            #1;
            if (!take && mret) begin
                st = (mstatus & ~32'h1888) | (mstatus[7] ? 32'h8 : 32'h0) | 32'h80;
                checks++; if (redirect !== 1'b1 || redirect_pc !== mepc_cur || mstatus_nxt !== st) begin errors++; $display("FAIL rnd_mret[%0d] got %b/%h/%h exp 1/%h/%h", n, redirect, redirect_pc, mstatus_nxt, mepc_cur, st); end
            end else begin
                checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL rnd_no_redirect[%0d] got %b exp 0", n, redirect); end
            end
            cyc();
            ex_valid = 0; mret = 0; exc_req = 0;
            checks++; if (trap !== take) begin errors++; $display("FAIL rnd_trap[%0d] got %b exp %b", n, trap, take); end
            if (take) begin
                st = (mstatus & ~32'h1888) | (mstatus[3] ? 32'h80 : 32'h0) | 32'h1800;
                checks++; if (mcause !== e_cause || mepc !== ex_pc || mtval !== e_tval) begin errors++; $display("FAIL rnd_csr[%0d] got %h/%h/%h exp %h/%h/%h", n, mcause, mepc, mtval, e_cause, ex_pc, e_tval); end
                checks++; if (mstatus_nxt !== st) begin errors++; $display("FAIL rnd_mstatus_nxt[%0d] got %h exp %h", n, mstatus_nxt, st); end
                cyc();
                checks++; if (redirect !== 1'b1 || redirect_pc !== e_vec) begin errors++; $display("FAIL rnd_vec[%0d] got %b/%h exp 1/%h", n, redirect, redirect_pc, e_vec); end
                cyc();
            end
        end
    endtask

    task automatic test_timer();
        bit seen;
        do_reset();
`ifdef TRAP_CTRL_TIMER_EN
        tmr_wr = 1; tmr_sel = 2'd2; tmr_wdata = 32'd10;
        cyc();
        tmr_sel = 2'd3; tmr_wdata = 32'd0;
        cyc();
        tmr_wr = 0;
        checks++; if (mip[7] !== 1'b0) begin errors++; $display("FAIL tmr_early_mtip got %b exp 0", mip[7]); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (mip[7]) begin
                seen = 1;
                break;
            end
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL tmr_mtip_timeout got %b exp 1", seen); end
        tmr_sel = 2'd0;
        #1;
        checks++; if (tmr_rdata !== 32'd11) begin errors++; $display("FAIL tmr_mtime_at_rise got %h exp b", tmr_rdata); end
        mstatus = 32'h8; mie = 32'h80; ex_valid = 1; ex_pc = 32'h700;
        cyc();
        ex_valid = 0; mie = 0;
        checks++; if (trap !== 1'b1 || mcause !== 32'h80000007) begin errors++; $display("FAIL tmr_trap got %b/%h exp 1/80000007", trap, mcause); end
        cyc();
        cyc();
        tmr_wr = 1; tmr_sel = 2'd1; tmr_wdata = 32'hFFFF_FFFF;
        cyc();
        tmr_sel = 2'd0; tmr_wdata = 32'hFFFF_FFFE;
        cyc();
        tmr_wr = 0;
        #1;
        checks++; if (tmr_rdata !== 32'hFFFF_FFFE) begin errors++; $display("FAIL tmr_lo_write got %h exp fffffffe", tmr_rdata); end
        tmr_sel = 2'd1;
        #1;
        checks++; if (tmr_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL tmr_hi_write got %h exp ffffffff", tmr_rdata); end
        cyc();
        cyc();
        checks++; if (tmr_rdata !== 32'd0) begin errors++; $display("FAIL tmr_wrap_hi got %h exp 0", tmr_rdata); end
        tmr_sel = 2'd0;
        #1;
        checks++; if (tmr_rdata !== 32'd0) begin errors++; $display("FAIL tmr_wrap_lo got %h exp 0", tmr_rdata); end
`else
        seen = 0;
        tmr_wr = 1; tmr_sel = 2'd2; tmr_wdata = 32'd0;
        cyc();
        tmr_wr = 0;
        cyc();
        for (int s = 0; s < 4; s++) begin
            tmr_sel = 2'(s);
            #1;
            if (tmr_rdata !== 32'd0) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL notmr_rdata got %b exp 0", seen); end
        checks++; if (mip[7] !== 1'b0) begin errors++; $display("FAIL notmr_mtip got %b exp 0", mip[7]); end
`endif
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_illegal();
        test_vectored();
        test_masked();
        test_simultaneous();
        test_mret();
        test_reset_mid_trap();
        test_random();
        test_timer();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
